// File: rtl/irst_controller.sv
// irst command sequencer: decodes the reg-0 command word, stalls the core, sweeps or counts, pulses done.
// Optional build macro IRST_ABORT_EN adds the irst_abort input to cut RUN/CLEAR short.
module irst_controller #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 12,
  parameter int NUM_REGS = 8,
  localparam int DEST_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef IRST_ABORT_EN
  input  logic              irst_abort,
`endif
  input  logic [DATA_W-1:0] irst_reg_data,
  output logic              irst_done,
  output logic              irst_active,
  output logic              irst_write_en,
  output logic [DEST_W-1:0] irst_write_dest,
  output logic [DATA_W-1:0] irst_write_data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_CLEAR    = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_CLR = 3'd4
  } state_t;

  localparam logic [2:0]        MODE_RUN   = 3'd1;
  localparam logic [2:0]        MODE_CLEAR = 3'd2;
  localparam logic [DEST_W-1:0] LAST_DEST  = DEST_W'(NUM_REGS - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               r_active;
  logic               r_we;
  logic [DEST_W-1:0]  r_dest;

  logic               w_start;
  logic [2:0]         w_mode;
  logic [CNT_W-1:0]   w_count;
  logic               w_abort;

  assign w_start = irst_reg_data[DATA_W-1];
  assign w_mode  = irst_reg_data[DATA_W-2 -: 3];
  assign w_count = irst_reg_data[CNT_W-1:0];

`ifdef IRST_ABORT_EN
  assign w_abort = irst_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Outputs are assigned alongside the state they belong to, so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
      r_we     <= 1'b0;
      r_dest   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_active <= 1'b1;
            case (w_mode)
              MODE_RUN: begin
                r_state <= S_RUN;
                r_cnt   <= w_count;
              end
              MODE_CLEAR: begin
                r_state <= S_CLEAR;
                r_we    <= 1'b1;
                r_dest  <= DEST_W'(1);
              end
              default: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_RUN: begin
          if (w_abort || r_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_abort || r_dest == LAST_DEST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_we    <= 1'b0;
            r_dest  <= '0;
          end else begin
            r_dest <= r_dest + 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_WAIT_CLR;
          r_done   <= 1'b0;
          r_active <= 1'b0;
        end
        // Hold off until reg 0 is cleared so the stale word cannot restart the sequence.
        S_WAIT_CLR: begin
          if (!w_start) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_active <= 1'b0;
          r_we     <= 1'b0;
          r_dest   <= '0;
        end
      endcase
    end
  end

  assign irst_done       = r_done;
  assign irst_active     = r_active;
  assign irst_write_en   = r_we;
  assign irst_write_dest = r_dest;
  assign irst_write_data = '0;

endmodule

// File: tb/tb_irst_controller.sv
// Directed + randomized bench for irst_controller against a per-cycle expected-output trace model.
module tb_irst_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] irst_reg_data;
  logic        irst_done;
  logic        irst_active;
  logic        irst_write_en;
  logic [2:0]  irst_write_dest;
  logic [15:0] irst_write_data;
`ifdef IRST_ABORT_EN
  logic        irst_abort;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  irst_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef IRST_ABORT_EN
    .irst_abort      (irst_abort),
`endif
    .irst_reg_data   (irst_reg_data),
    .irst_done       (irst_done),
    .irst_active     (irst_active),
    .irst_write_en   (irst_write_en),
    .irst_write_dest (irst_write_dest),
    .irst_write_data (irst_write_data)
  );

  always #5 clk = ~clk;

  // Observed tuple: {active, done, write_en, dest[2:0], write_data[15:0]}
  logic [21:0] obs;
  assign obs = {irst_active, irst_done, irst_write_en, irst_write_dest, irst_write_data};

  function automatic logic [21:0] pk(input logic a, input logic d, input logic we,
                                     input logic [2:0] dest);
    return {a, d, we, dest, 16'h0000};
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Builds the expected per-cycle output trace of one command from its word, then compares
  // it cycle by cycle. The word must already be applied; the next edge samples it.
  task automatic expect_seq(input logic [15:0] w, input int max_n, input bit scramble,
                            input string tag);
    logic [21:0] q[$];
    int          c;
    logic [2:0]  m;
    m = w[14:12];
    c = int'(w[11:0]);
    if (w[15]) begin
      if (m == 3'd1) begin
        for (int i = 0; i <= c; i++) q.push_back(pk(1'b1, 1'b0, 1'b0, 3'd0));
      end else if (m == 3'd2) begin
        for (int d = 1; d < 8; d++) q.push_back(pk(1'b1, 1'b0, 1'b1, 3'(d)));
      end
      q.push_back(pk(1'b1, 1'b1, 1'b0, 3'd0));
    end
    for (int i = 0; i < q.size() && (max_n < 0 || i < max_n); i++) begin
      @(posedge clk); #1;
      check(tag, obs, q[i]);
      // A different live command mid-sequence must be ignored.
      if (i == 0 && scramble) irst_reg_data = {1'b1, 3'($urandom), 12'($urandom)};
    end
  endtask

  // Called right after the done cycle: stale word held for `hold` cycles, then reg 0 clears.
  task automatic finish_cmd(input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, obs, 22'h0);
    end
    irst_reg_data = 16'h0000;
    @(posedge clk); #1;
    check({tag, "_wait"}, obs, 22'h0);
    @(posedge clk); #1;
    check({tag, "_idle"}, obs, 22'h0);
  endtask

  initial begin
    logic [15:0] w;
    clk           = 1'b0;
    rst_n         = 1'b0;
    irst_reg_data = 16'h97FF;
`ifdef IRST_ABORT_EN
    irst_abort    = 1'b0;
`endif
    #12;
    check("reset", obs, 22'h0);

    // Reset release with a long RUN command already in reg 0.
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_seq(16'h97FF, -1, 1'b0, "run_7ff");
    finish_cmd(0, "run_7ff");

    @(posedge clk); #1;
    irst_reg_data = 16'hA000;
    expect_seq(16'hA000, -1, 1'b0, "clear");
    finish_cmd(0, "clear");

    @(posedge clk); #1;
    irst_reg_data = 16'h9000;
    expect_seq(16'h9000, -1, 1'b0, "run_0");
    finish_cmd(0, "run_0");

    @(posedge clk); #1;
    irst_reg_data = 16'hB123;
    expect_seq(16'hB123, -1, 1'b0, "reserved");
    finish_cmd(5, "reserved");

    @(posedge clk); #1;
    irst_reg_data = 16'h9002;
    expect_seq(16'h9002, -1, 1'b0, "run_2");
    finish_cmd(0, "run_2");

    // Asynchronous reset mid-CLEAR while dest==4, then the re-presented word restarts.
    @(posedge clk); #1;
    irst_reg_data = 16'hA000;
    expect_seq(16'hA000, 4, 1'b0, "clr_pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("clr_async_rst", obs, 22'h0);
    @(posedge clk); #1;
    check("clr_in_rst", obs, 22'h0);
    rst_n = 1'b1;
    expect_seq(16'hA000, -1, 1'b0, "clr_restart");
    finish_cmd(0, "clr_restart");

`ifdef IRST_ABORT_EN
    @(posedge clk); #1;
    irst_reg_data = 16'h90FF;
    expect_seq(16'h90FF, 10, 1'b0, "abort_run");
    irst_abort = 1'b1;
    @(posedge clk); #1;
    check("abort_done", obs, pk(1'b1, 1'b1, 1'b0, 3'd0));
    irst_abort = 1'b0;
    finish_cmd(0, "abort");
`endif

    // Randomized commands, including idle words and reserved modes.
    for (int k = 0; k < 16; k++) begin
      w = {($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 12'($urandom_range(0, 40))};
      @(posedge clk); #1;
      irst_reg_data = w;
      if (w[15]) begin
        expect_seq(w, -1, ($urandom_range(0, 1) == 1), "rand");
        finish_cmd($urandom_range(0, 3), "rand");
      end else begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          check("rand_nostart", obs, 22'h0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
